// File: rtl/ps_pkt_fifo.sv
// Store-and-forward packet FIFO for PacketStream (dat/val/eop/rdy), cut-through fallback for oversize packets.
// Latency: eop accepted at edge k -> first word of that packet on o_dat/o_val after edge k+2.
// Backpressure: i_rdy drops when DEPTH unconsumed words are held; output word held stable while o_rdy is low.
module ps_pkt_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic [DWIDTH-1:0]        i_dat,
    input  logic                     i_val,
    input  logic                     i_eop,
    output logic                     i_rdy,
    output logic [DWIDTH-1:0]        o_dat,
    output logic                     o_val,
    output logic                     o_eop,
    input  logic                     o_rdy,
    output logic [$clog2(DEPTH):0]   o_pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic {ST_STORE = 1'b0, ST_CUT = 1'b1} state_t;

    // {dat, eop} per word
    logic [DWIDTH:0] mem [DEPTH];

    logic [AW:0]     wr_ptr;   // next write slot
    logic [AW:0]     cmt_ptr;  // end of committed (releasable) data
    logic [AW:0]     rd_ptr;   // next slot to fetch into the read pipeline
    logic [AW:0]     rel_ptr;  // oldest word not yet consumed downstream
    logic [AW:0]     used;

    logic            a_vld;    // RAM read register holds a word
    logic [DWIDTH:0] a_word;

    state_t          state;
    state_t          state_nxt;
    logic            cmt_adv;  // commit everything up to and including the word being written
    logic            cmt_cut;  // commit everything already written (entering cut-through)

    logic            full;
    logic            wr_en;
    logic            avail;
    logic            ld_out;
    logic            ld_ram;
    logic            fetch;
    logic            cmt_empty;
    logic            pkt_inc;
    logic            pkt_dec;

    // Words in the read pipeline still occupy their slots until consumed, so a full
    // buffer only frees space once downstream actually takes a word.
    assign rel_ptr   = rd_ptr - (AW+1)'(a_vld) - (AW+1)'(o_val);
    assign used      = wr_ptr - rel_ptr;
    assign full      = (used == DEPTH_W);
    assign i_rdy     = ~full;
    assign wr_en     = i_val & i_rdy;
    assign avail     = (rd_ptr != cmt_ptr);
    assign cmt_empty = (cmt_ptr == rel_ptr);
    assign ld_out    = ~o_val | o_rdy;
    assign ld_ram    = ~a_vld | ld_out;
    assign fetch     = ld_ram & avail;
    assign pkt_inc   = wr_en & i_eop;
    assign pkt_dec   = o_val & o_rdy & o_eop;

    // Storage write and registered RAM read (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {i_dat, i_eop};
        end
        if (fetch) begin
            a_word <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Write pointer advances on every accepted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_STORE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a packet that alone fills the buffer switches to cut-through
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STORE: if (full && cmt_empty) state_nxt = ST_CUT;
            ST_CUT:   if (wr_en && i_eop)    state_nxt = ST_STORE;
            default:  state_nxt = ST_STORE;
        endcase
    end

    // FSM outputs: how the commit pointer moves this cycle
    always_comb begin
        cmt_adv = 1'b0;
        cmt_cut = 1'b0;
        case (state)
            ST_STORE: begin
                cmt_adv = wr_en & i_eop;
                cmt_cut = full & cmt_empty;
            end
            ST_CUT: begin
                cmt_adv = wr_en;
            end
            default: begin
                cmt_adv = 1'b0;
                cmt_cut = 1'b0;
            end
        endcase
    end

    // Commit pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmt_ptr <= '0;
        end else if (cmt_adv) begin
            cmt_ptr <= wr_ptr + PTR_ONE;
        end else if (cmt_cut) begin
            cmt_ptr <= wr_ptr;
        end
    end

    // Two-stage show-ahead read pipeline: RAM read register then output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            a_vld  <= 1'b0;
            o_val  <= 1'b0;
            o_dat  <= '0;
            o_eop  <= 1'b0;
        end else begin
            if (ld_ram) begin
                a_vld <= avail;
                if (avail) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
            if (ld_out) begin
                o_val <= a_vld;
                if (a_vld) begin
                    o_dat <= a_word[DWIDTH:1];
                    o_eop <= a_word[0];
                end
            end
        end
    end

    // Count of packets whose eop is written but not yet consumed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_pkt_cnt <= '0;
        end else if (pkt_inc && !pkt_dec) begin
            o_pkt_cnt <= o_pkt_cnt + (AW+1)'(1);
        end else if (pkt_dec && !pkt_inc) begin
            o_pkt_cnt <= o_pkt_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: tb/tb_ps_pkt_fifo.sv
module tb_ps_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] i_dat;
    logic          i_val;
    logic          i_eop;
    logic          i_rdy;
    logic [DW-1:0] o_dat;
    logic          o_val;
    logic          o_eop;
    logic          o_rdy;
    logic [AW:0]   o_pkt_cnt;

    ps_pkt_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
        .reset    (reset),
        .clk      (clk),
        .i_dat    (i_dat),
        .i_val    (i_val),
        .i_eop    (i_eop),
        .i_rdy    (i_rdy),
        .o_dat    (o_dat),
        .o_val    (o_val),
        .o_eop    (o_eop),
        .o_rdy    (o_rdy),
        .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: words held in the buffer until consumed downstream
    typedef struct {
        logic [DW-1:0] dat;
        logic          eop;
        logic          cutf;   // committed through cut-through, gaps allowed
    } wrd_t;

    wrd_t mq[$];
    int   n_cmt;          // leading words of mq released to the reader
    bit   m_cut;          // writer is streaming an oversize packet
    bit   prev_cons_mid;  // last edge consumed a non-final word of a stored packet
    int   n_chk;
    int   n_pass;
    int   n_fail;
    int   rmode;          // 0: o_rdy low, 1: high, 2: toggle, 3: random
    logic tgl;
    int   pk_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_eops();
        int c = 0;
        foreach (mq[i]) if (mq[i].eop) c++;
        return c;
    endfunction

    task automatic rpick(output logic r);
        case (rmode)
            0: r = 1'b0;
            1: r = 1'b1;
            2: begin tgl = ~tgl; r = tgl; end
            default: r = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic mcheck();
        chk("i_rdy", 32'(i_rdy), 32'(mq.size() != DEPTH));
        chk("o_pkt_cnt", 32'(o_pkt_cnt), 32'(m_eops()));
        if (prev_cons_mid) chk("no_gap", 32'(o_val), 32'd1);
        if (o_val === 1'b1) begin
            chk("o_val_committed", 32'(n_cmt > 0), 32'd1);
            if (mq.size() > 0) begin
                chk("o_dat", 32'(o_dat), 32'(mq[0].dat));
                chk("o_eop", 32'(o_eop), 32'(mq[0].eop));
            end
        end else begin
            chk("o_val_known", 32'(o_val), 32'd0);
        end
    endtask

    // One clock: drive, check at negedge, advance model at posedge
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic r, output bit acc);
        bit   cons;
        bit   cut_go;
        wrd_t w;
        i_val = v; i_dat = d; i_eop = e; o_rdy = r;
        @(negedge clk);
        mcheck();
        if (o_pkt_cnt > pk_max[AW:0]) pk_max = int'(o_pkt_cnt);
        acc  = v && (mq.size() != DEPTH);
        cons = (o_val === 1'b1) && r;
        @(posedge clk);
        prev_cons_mid = 1'b0;
        cut_go = !m_cut && (mq.size() == DEPTH) && (n_cmt == 0);
        if (cons && mq.size() > 0) begin
            w = mq.pop_front();
            if (n_cmt > 0) n_cmt--;
            prev_cons_mid = !w.eop && !w.cutf;
        end
        if (cut_go) begin
            m_cut = 1'b1;
            for (int i = 0; i < mq.size(); i++) mq[i].cutf = 1'b1;
            n_cmt = mq.size();
        end
        if (acc) begin
            mq.push_back('{dat: d, eop: e, cutf: m_cut});
            if (m_cut || e) n_cmt = mq.size();
            if (m_cut && e) m_cut = 1'b0;
        end
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic e);
        bit   acc;
        int   t = 0;
        logic r;
        do begin
            rpick(r);
            cyc(1'b1, d, e, r, acc);
            t++;
        end while (!acc && t < 200);
        chk("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        bit   acc;
        logic r;
        for (int i = 0; i < n; i++) begin
            rpick(r);
            cyc(1'b0, '0, 1'b0, r, acc);
        end
    endtask

    task automatic drain();
        bit acc;
        int t = 0;
        while ((mq.size() != 0 || o_val !== 1'b0) && t < 500) begin
            cyc(1'b0, '0, 1'b0, 1'b1, acc);
            t++;
        end
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_o_val"}, 32'(o_val), 32'd0);
        chk({tag, "_o_dat"}, 32'(o_dat), 32'd0);
        chk({tag, "_o_eop"}, 32'(o_eop), 32'd0);
        chk({tag, "_o_pkt_cnt"}, 32'(o_pkt_cnt), 32'd0);
        chk({tag, "_i_rdy"}, 32'(i_rdy), 32'd1);
    endtask

    task automatic do_reset();
        i_val = 1'b0; i_eop = 1'b0; i_dat = '0; o_rdy = 1'b0;
        reset = 1'b1;
        #2;
        chk_reset_vals("rst_during");
        mq.delete();
        n_cmt = 0; m_cut = 1'b0; prev_cons_mid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   plen;
        bit   acc;
        n_chk = 0; n_pass = 0; n_fail = 0;
        tgl = 1'b0; pk_max = 0; rmode = 0;
        mq.delete(); n_cmt = 0; m_cut = 1'b0; prev_cons_mid = 1'b0;
        i_val = 1'b0; i_eop = 1'b0; i_dat = '0; o_rdy = 1'b0;
        reset = 1'b1;
        #2;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #3;
        chk_reset_vals("after_reset");

        // 1) three-word packet, first word two edges after the eop write
        rmode = 1;
        send(8'hA0, 1'b0);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        chk("t1_val_e2", 32'(o_val), 32'd0);
        idle(1);
        chk("t1_val_e3", 32'(o_val), 32'd0);
        idle(1);
        chk("t1_val_e4", 32'(o_val), 32'd1);
        chk("t1_dat_e4", 32'(o_dat), 32'hA0);
        chk("t1_eop_e4", 32'(o_eop), 32'd0);
        idle(1);
        chk("t1_dat_e5", 32'(o_dat), 32'hA1);
        idle(1);
        chk("t1_dat_e6", 32'(o_dat), 32'hA2);
        chk("t1_eop_e6", 32'(o_eop), 32'd1);
        idle(1);
        chk("t1_val_e7", 32'(o_val), 32'd0);

        // 2) back-to-back 5-word packets with o_rdy toggling
        rmode = 2; tgl = 1'b0; pk_max = 0;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 5; i++)
                send(8'(8'h50 + p * 16 + i), 1'(i == 4));
        drain();
        chk("t2_pkt_peak", 32'(pk_max), 32'd2);
        chk("t2_pkt_end", 32'(o_pkt_cnt), 32'd0);

        // 3) two 4-word packets fill the buffer; one consume frees a slot
        rmode = 0;
        for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 1'(i % 4 == 3));
        chk("t3_full_rdy", 32'(i_rdy), 32'd0);
        chk("t3_pkt_cnt", 32'(o_pkt_cnt), 32'd2);
        idle(1);
        chk("t3_still_full", 32'(i_rdy), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1, acc);
        chk("t3_rdy_after_pulse", 32'(i_rdy), 32'd1);
        drain();

        // 4) 12-word packet falls back to cut-through
        rmode = 0;
        for (int i = 0; i < 8; i++) send(8'(8'h80 + i), 1'b0);
        chk("t4_full_rdy", 32'(i_rdy), 32'd0);
        chk("t4_val_before_cut", 32'(o_val), 32'd0);
        idle(3);
        chk("t4_val_cut", 32'(o_val), 32'd1);
        chk("t4_dat_cut", 32'(o_dat), 32'h80);
        chk("t4_pkt_cnt_cut", 32'(o_pkt_cnt), 32'd0);
        rmode = 1;
        for (int i = 8; i < 12; i++) send(8'(8'h80 + i), 1'(i == 11));
        drain();
        rmode = 0;
        send(8'h90, 1'b0);
        idle(4);
        chk("t4_store_hold", 32'(o_val), 32'd0);
        send(8'h91, 1'b1);
        idle(2);
        chk("t4_store_val", 32'(o_val), 32'd1);
        chk("t4_store_dat", 32'(o_dat), 32'h90);
        drain();

        // 5) reset with a stored packet and a partial one
        rmode = 0;
        for (int i = 0; i < 3; i++) send(8'(8'hB0 + i), 1'(i == 2));
        send(8'hB8, 1'b0);
        send(8'hB9, 1'b0);
        do_reset();
        #3;
        chk_reset_vals("t5_after");
        rmode = 1;
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b1);
        idle(2);
        chk("t5_val", 32'(o_val), 32'd1);
        chk("t5_dat", 32'(o_dat), 32'hC0);
        drain();

        // 6) eop written in the same cycle an eop is consumed
        rmode = 0;
        send(8'hD0, 1'b1);
        idle(2);
        chk("t6_val", 32'(o_val), 32'd1);
        chk("t6_cnt_before", 32'(o_pkt_cnt), 32'd1);
        cyc(1'b1, 8'hD1, 1'b1, 1'b1, acc);
        chk("t6_acc", 32'(acc), 32'd1);
        chk("t6_cnt_after", 32'(o_pkt_cnt), 32'd1);
        drain();

        // Random traffic, including oversize packets
        rmode = 3;
        for (int p = 0; p < 250; p++) begin
            if ($urandom_range(0, 7) == 0) plen = $urandom_range(9, 14);
            else plen = $urandom_range(1, 6);
            for (int i = 0; i < plen; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send(8'($urandom), 1'(i == plen - 1));
            end
        end
        drain();
        chk("final_pkt_cnt", 32'(o_pkt_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
